// File: rtl/y86_bus_pkg.sv
// Shared constants for the y86 bus responder: MMIO window, register offsets
// and STATUS bit layout.
package y86_bus_pkg;

  localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CLR    = 8'h08;
  localparam logic [7:0] OFF_RDCNT  = 8'h10;
  localparam logic [7:0] OFF_WRCNT  = 8'h14;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_CNT_W = 6;

endpackage

// File: rtl/y86_tx_fifo.sv
// Console transmit FIFO, 8-bit wide. A push while full is accepted only if a
// pop frees a slot in the same cycle; otherwise it is dropped and flagged.
module y86_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    wdata,
  input  logic                          pop_req,
  output logic [7:0]                    rdata,
  output logic                          valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          drop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    slot [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign valid   = count != '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign do_pop  = pop_req && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = valid ? slot[rd_ptr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/y86_bus_mem.sv
// Bus responder for the y86 core: byte-addressed little-endian RAM with
// unaligned 32-bit access, plus MMIO console FIFO. Y86_MEM_STATS_EN adds counters.
module y86_bus_mem
  import y86_bus_pkg::*;
#(
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_A,
  input  logic        bus_RE,
  input  logic        bus_WE,
  input  logic [31:0] bus_out,
  output logic [31:0] bus_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] addr [4];
  logic          mmio_sel;
  logic [7:0]    off;
  logic          push, clr, full, drop;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   ram_rd, mmio_rd, status;

  assign mmio_sel = bus_A[31:8] == MMIO_BASE;
  assign off      = bus_A[7:0];
  assign push     = bus_WE && mmio_sel && off == OFF_TXDATA;
  assign clr      = bus_WE && mmio_sel && off == OFF_CLR;

  // Byte lanes wrap modulo the RAM size, so no alignment is needed.
  always_comb begin
    for (int k = 0; k < 4; k++) addr[k] = bus_A[AW-1:0] + AW'(k);
  end

  assign ram_rd = {mem[addr[3]], mem[addr[2]], mem[addr[1]], mem[addr[0]]};

  always_ff @(posedge clk) begin
    if (bus_WE && !mmio_sel) begin
      for (int k = 0; k < 4; k++) mem[addr[k]] <= bus_out[8*k +: 8];
    end
  end

  y86_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (bus_out[7:0]),
    .pop_req (tx_ready),
    .rdata   (tx_data),
    .valid   (tx_valid),
    .full    (full),
    .count   (count),
    .drop    (drop)
  );

  // Error/overflow events take priority over a same-cycle CLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (drop)                 ovf <= 1'b1;
      else if (clr)             ovf <= 1'b0;
      if (bus_RE && bus_WE)     err <= 1'b1;
      else if (clr)             err <= 1'b0;
    end
  end

`ifdef Y86_MEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (clr) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (bus_RE && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (bus_WE && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    status                       = '0;
    status[ST_OVF]               = ovf;
    status[ST_FULL]              = full;
    status[ST_CNT_W-1:0]         = ST_CNT_W'(count);
  end

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_STATUS: mmio_rd = status;
`ifdef Y86_MEM_STATS_EN
      OFF_RDCNT:  mmio_rd = rd_cnt;
      OFF_WRCNT:  mmio_rd = wr_cnt;
`endif
      default:    mmio_rd = '0;
    endcase
  end

  assign bus_in = !bus_RE ? 32'h0 : (mmio_sel ? mmio_rd : ram_rd);

endmodule

// File: doc/y86_bus_mem.md
# y86_bus_mem

Bus responder for the y86 sequential core: answers the core's bus_A / bus_RE / bus_WE / bus_out / bus_in interface with byte-addressed, little-endian RAM that supports unaligned 32-bit reads and writes. It also provides a memory-mapped console transmit FIFO with a valid/ready drain port. It sits between the core and the testbench/SoC top, and its read data is combinational because the core samples bus_in in the same cycle it asserts bus_RE.

## Interface
- AW, 12: RAM address width; RAM holds 2^AW bytes.
- FIFO_DEPTH, 4: console FIFO entries; power of two, at least 2.
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous, active-high reset.
- bus_A in 32: byte address from the core.
- bus_RE in 1: read strobe.
- bus_WE in 1: write strobe.
- bus_out in 32: write data from the core.
- bus_in out 32: read data to the core.
- tx_data out 8: console byte at the FIFO head.
- tx_valid out 1: FIFO is non-empty.
- tx_ready in 1: consumer accepts the head byte.
- err out 1: sticky protocol error.

## Operation
- Address decode:
  - bus_A[31:8] == 24'hFFFFFF selects MMIO.
  - Any other address selects RAM at (bus_A + k) mod 2^AW for byte k = 0..3. Accesses wrap around the top of RAM and need no alignment.
- RAM read: bus_in = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, combinational.
- RAM write: on a clk edge with bus_WE=1, mem[a+k] <= bus_out[8k+7:8k] for k = 0..3.
- MMIO registers:
  - 0xFFFFFF00 TXDATA: a write pushes bus_out[7:0]. A read returns 0.
  - 0xFFFFFF04 STATUS (read): {24'b0, ovf, full, count[5:0]}, where count is the FIFO occupancy.
  - 0xFFFFFF08 CLR (write): clears ovf and err. The data value is ignored.
  - Any other MMIO address reads 0; writes to it are ignored.
- FIFO rules:
  - Push while full drops the byte and sets the sticky ovf.
  - Pop occurs when tx_valid && tx_ready.
  - Push and pop in the same cycle when full: the pop happens, the push is accepted, and count is unchanged.
  - Push and pop in the same cycle when empty: the push is accepted, there is no pop, and count becomes 1.
- bus_in is 0 whenever bus_RE=0.
- err is set on any cycle with bus_RE && bus_WE. In that cycle the write still commits and the read returns pre-write data.
- CLR and a new err or ovf event in the same cycle: set wins.

## Timing
- Reads have zero latency; bus_in is a combinational function of bus_A, bus_RE, memory and register state.
- Writes, pushes and pops take effect at the clk edge. The next cycle's read sees the new data, i.e. read-after-write is visible one cycle later.
- Reset values:
  - FIFO empty, so tx_valid=0 and tx_data=0.
  - ovf=0, err=0, bus_in=0 (bus_RE is low in reset per protocol).
  - RAM contents are not reset. They are preloaded by the bench.
- Reset asserted mid-operation flushes the FIFO immediately, asynchronously; RAM is untouched.
- tx_data must hold stable while tx_valid=1 && tx_ready=0.

## Configuration
- Y86_MEM_STATS_EN defined:
  - Adds a 32-bit read counter, incremented per bus_RE cycle, mapped at 0xFFFFFF10.
  - Adds a 32-bit write counter, incremented per bus_WE cycle, mapped at 0xFFFFFF14.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0, and are cleared by a CLR write.
- Y86_MEM_STATS_EN not defined: no counters exist, and 0xFFFFFF10/14 read 0 like any unmapped MMIO address.

## Structure
- Package y86_bus_pkg holds:
  - the MMIO base 24'hFFFFFF and register offsets TXDATA=8'h00, STATUS=8'h04, CLR=8'h08, RDCNT=8'h10, WRCNT=8'h14;
  - the STATUS bit positions.
- Sub-module y86_tx_fifo (parameter FIFO_DEPTH, 8-bit): push/pop, full/empty, count, async reset.

## Test plan
- Preload bytes 0x10..0x13 = 8B 45 08 89 -> read at 0x010 gives bus_in=32'h8908458B; read at 0x011 gives 32'hxx890845 with byte 0x14 in the top.
- Unaligned write 32'hAABBCCDD at 2^AW-2 -> bytes FFE=DD, FFF=CC, 000=BB, 001=AA (AW=12); a read-back at the same address next cycle returns 32'hAABBCCDD.
- Five writes to 0xFFFFFF00 with tx_ready=0 and FIFO_DEPTH=4 -> STATUS reads 0xC4 (ovf=1, full=1, count=4); raising tx_ready drains the first four bytes in order; a CLR write then makes STATUS read 0.
- FIFO full, push and tx_ready=1 in the same cycle -> count stays 4, ovf stays 0, and the head advances.
- bus_RE=bus_WE=1 at 0x020 with old data 0 and bus_out=1 -> bus_in=0 that cycle, err=1 on the next cycle, and mem reads 1 afterwards.
- With Y86_MEM_STATS_EN: 3 reads then 2 writes -> 0xFFFFFF10 reads 3 (the counter read itself is counted afterwards) and 0xFFFFFF14 reads 2; rst asserted mid-sequence zeroes both counters and tx_valid immediately.
